// File: rtl/dl_mem_arbiter_if.sv
// Bundle of the download, CPU, erase and memory-port signals around dl_mem_arbiter.
// master = arbiter side, slave = surrounding units (download, CPU, erase control, memory).
interface dl_mem_arbiter_if #(
    parameter int unsigned AW = 25
);
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_overflow;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;

    logic          erase_start;
    logic [AW-1:0] erase_base;
    logic [AW-1:0] erase_end;
    logic          erasing;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_ack;

    modport master (
        input  dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din,
               erase_start, erase_base, erase_end, mem_dout, mem_ack,
        output dl_overflow, cpu_dout, cpu_ack, erasing, mem_req, mem_we, mem_addr, mem_din
    );

    modport slave (
        output dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din,
               erase_start, erase_base, erase_end, mem_dout, mem_ack,
        input  dl_overflow, cpu_dout, cpu_ack, erasing, mem_req, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dl_mem_arbiter.sv
// Shares one memory port between the buffered download stream and CPU req/ack accesses.
// Optional lowest-priority zero-fill engine is enabled by defining DL_MEM_ERASE_EN.
module dl_mem_arbiter #(
    parameter int unsigned AW            = 25,
    parameter int unsigned DL_FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    dl_mem_arbiter_if.master io_bus
);
    localparam int unsigned PW = $clog2(DL_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DL,
        S_CPU
`ifdef DL_MEM_ERASE_EN
        , S_ER
`endif
    } state_t;

    state_t        r_state;
    logic          r_last_dl;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_din;
    logic          r_cpu_ack;
    logic [7:0]    r_cpu_dout;
    logic          r_dl_overflow;

    logic [AW-1:0] r_fifo_addr [DL_FIFO_DEPTH];
    logic [7:0]    r_fifo_data [DL_FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_pop;
    logic w_push;
    logic w_cpu_pend;
    logic w_pick_cpu;
    logic w_erasing;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(DL_FIFO_DEPTH));
    assign w_pop        = (r_state == S_DL) && io_bus.mem_ack;
    // A full FIFO still accepts a strobe when the head retires on the same edge.
    assign w_push       = io_bus.dl_wr && (!w_fifo_full || w_pop);
    assign w_cpu_pend   = io_bus.cpu_req && !r_cpu_ack;
    // CPU wins right after a DL access, or whenever there is no download work.
    assign w_pick_cpu   = w_cpu_pend && (r_last_dl || w_fifo_empty);

    // Download FIFO and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_dl_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= io_bus.dl_addr;
                r_fifo_data[r_wr_ptr] <= io_bus.dl_data;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (io_bus.dl_wr && !w_push) begin
                r_dl_overflow <= 1'b1;
            end
        end
    end

`ifdef DL_MEM_ERASE_EN
    logic [AW-1:0] r_erase_ptr;
    logic [AW-1:0] r_erase_end;
    logic          r_erasing;
    logic          r_er_restart;
    logic [AW-1:0] w_erase_next;

    assign w_erase_next = r_erase_ptr + AW'(1);
    assign w_erasing    = r_erasing;

    // Zero-fill pointer; a restart during an ER access keeps that access from advancing the new base.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_erase_ptr  <= '0;
            r_erase_end  <= '0;
            r_erasing    <= 1'b0;
            r_er_restart <= 1'b0;
        end else if (io_bus.erase_start) begin
            r_erase_ptr  <= io_bus.erase_base;
            r_erase_end  <= io_bus.erase_end;
            r_erasing    <= (io_bus.erase_base != io_bus.erase_end);
            r_er_restart <= (r_state == S_ER) && !io_bus.mem_ack;
        end else if ((r_state == S_ER) && io_bus.mem_ack) begin
            r_er_restart <= 1'b0;
            if (!r_er_restart) begin
                r_erase_ptr <= w_erase_next;
                if (w_erase_next == r_erase_end) begin
                    r_erasing <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_erase;

    assign w_unused_erase = ^{io_bus.erase_start, io_bus.erase_base, io_bus.erase_end};
    assign w_erasing      = 1'b0;
`endif

    // Access FSM; every access is followed by exactly one IDLE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_dl  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_cpu_ack  <= 1'b0;
            r_cpu_dout <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_cpu) begin
                        r_state    <= S_CPU;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= io_bus.cpu_we;
                        r_mem_addr <= io_bus.cpu_addr;
                        r_mem_din  <= io_bus.cpu_din;
                    end else if (!w_fifo_empty) begin
                        r_state    <= S_DL;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_fifo_addr[r_rd_ptr];
                        r_mem_din  <= r_fifo_data[r_rd_ptr];
                    end
`ifdef DL_MEM_ERASE_EN
                    else if (r_erasing) begin
                        r_state    <= S_ER;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_erase_ptr;
                        r_mem_din  <= 8'h00;
                    end
`endif
                end
                S_DL: begin
                    if (io_bus.mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_last_dl <= 1'b1;
                    end
                end
                S_CPU: begin
                    if (io_bus.mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_last_dl <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        if (!r_mem_we) begin
                            r_cpu_dout <= io_bus.mem_dout;
                        end
                    end
                end
`ifdef DL_MEM_ERASE_EN
                S_ER: begin
                    if (io_bus.mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.mem_req     = r_mem_req;
    assign io_bus.mem_we      = r_mem_we;
    assign io_bus.mem_addr    = r_mem_addr;
    assign io_bus.mem_din     = r_mem_din;
    assign io_bus.cpu_ack     = r_cpu_ack;
    assign io_bus.cpu_dout    = r_cpu_dout;
    assign io_bus.dl_overflow = r_dl_overflow;
    assign io_bus.erasing     = w_erasing;
endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Self-checking bench for dl_mem_arbiter: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations. Erase scenarios need DL_MEM_ERASE_EN.
module tb_dl_mem_arbiter;
    localparam int unsigned AW    = 25;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dl_mem_arbiter_if #(.AW(AW)) bus_if ();

    dl_mem_arbiter #(.AW(AW), .DL_FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks ack_lat cycles after mem_req rises, or once on inject_ack
    int         ack_lat    = 2;
    logic       resp_hold  = 1'b0;
    logic       inject_ack = 1'b0;
    logic [7:0] rd_val     = 8'h00;
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        bus_if.mem_ack  = 1'b0;
        bus_if.mem_dout = 8'h00;
        forever begin
            tick();
            if (bus_if.mem_ack) begin
                bus_if.mem_ack = 1'b0;
            end else if (inject_ack) begin
                bus_if.mem_ack  = 1'b1;
                bus_if.mem_dout = rd_val;
            end else if (bus_if.mem_req && !resp_hold) begin
                lat_cnt++;
                if (lat_cnt >= ack_lat) begin
                    bus_if.mem_ack  = 1'b1;
                    bus_if.mem_dout = rd_val;
                end
            end
            if (!bus_if.mem_req) lat_cnt = 0;
        end
    end

    // Reference model: pending download queue, one outstanding access, alternating fairness
    typedef enum int {K_DL, K_CPU, K_ER} kind_t;
    logic [AW-1:0] mq_addr [$];
    logic [7:0]    mq_data [$];
    kind_t         m_kind       = K_DL;
    logic          m_busy       = 1'b0;
    logic          m_last_dl    = 1'b0;
    logic [AW-1:0] m_er_ptr     = '0;
    logic [AW-1:0] m_er_end     = '0;
    logic          m_er_restart = 1'b0;
    logic          e_req = 1'b0, e_we = 1'b0, e_ack = 1'b0, e_ovf = 1'b0, e_erasing = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [7:0]    e_din = '0, e_dout = '0;

    always @(posedge clk) begin
        logic cpu_pend, new_ack;
        if (reset) begin
            mq_addr.delete(); mq_data.delete();
            m_busy = 1'b0; m_last_dl = 1'b0; m_er_restart = 1'b0;
            m_er_ptr = '0; m_er_end = '0;
            e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
            e_ack = 1'b0; e_dout = '0; e_ovf = 1'b0; e_erasing = 1'b0;
        end else begin
            cpu_pend = bus_if.cpu_req && !e_ack;
            new_ack  = 1'b0;
            if (m_busy && bus_if.mem_ack) begin
                m_busy = 1'b0;
                e_req  = 1'b0;
                if (m_kind == K_DL) begin
                    void'(mq_addr.pop_front()); void'(mq_data.pop_front());
                    m_last_dl = 1'b1;
                end else if (m_kind == K_CPU) begin
                    m_last_dl = 1'b0;
                    new_ack   = 1'b1;
                    if (!e_we) e_dout = bus_if.mem_dout;
                end else begin
                    if (!m_er_restart) begin
                        m_er_ptr = m_er_ptr + AW'(1);
                        if (m_er_ptr == m_er_end) e_erasing = 1'b0;
                    end
                    m_er_restart = 1'b0;
                end
            end else if (!m_busy) begin
                if (cpu_pend && (m_last_dl || mq_addr.size() == 0)) begin
                    m_kind = K_CPU; m_busy = 1'b1; e_req = 1'b1;
                    e_we = bus_if.cpu_we; e_addr = bus_if.cpu_addr; e_din = bus_if.cpu_din;
                end else if (mq_addr.size() != 0) begin
                    m_kind = K_DL; m_busy = 1'b1; e_req = 1'b1;
                    e_we = 1'b1; e_addr = mq_addr[0]; e_din = mq_data[0];
                end else if (e_erasing) begin
                    m_kind = K_ER; m_busy = 1'b1; e_req = 1'b1;
                    e_we = 1'b1; e_addr = m_er_ptr; e_din = 8'h00;
                end
            end
            if (bus_if.dl_wr) begin
                if (mq_addr.size() < int'(DEPTH)) begin
                    mq_addr.push_back(bus_if.dl_addr);
                    mq_data.push_back(bus_if.dl_data);
                end else begin
                    e_ovf = 1'b1;
                end
            end
`ifdef DL_MEM_ERASE_EN
            if (bus_if.erase_start) begin
                if (m_busy && m_kind == K_ER) m_er_restart = 1'b1;
                m_er_ptr  = bus_if.erase_base;
                m_er_end  = bus_if.erase_end;
                e_erasing = (bus_if.erase_base != bus_if.erase_end);
            end
`endif
            e_ack = new_ack;
        end
    end

    // Per-cycle compare and access log of what the DUT actually issued
    logic [AW+8:0] log_q [$];
    logic          prev_req  = 1'b0;
    int            n_cpu_ack = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(bus_if.mem_req), 32'(e_req));
            if (e_req) begin
                chk("mem_we", 32'(bus_if.mem_we), 32'(e_we));
                chk("mem_addr", 32'(bus_if.mem_addr), 32'(e_addr));
                chk("mem_din", 32'(bus_if.mem_din), 32'(e_din));
            end
            chk("cpu_ack", 32'(bus_if.cpu_ack), 32'(e_ack));
            chk("cpu_dout", 32'(bus_if.cpu_dout), 32'(e_dout));
            chk("dl_overflow", 32'(bus_if.dl_overflow), 32'(e_ovf));
            chk("erasing", 32'(bus_if.erasing), 32'(e_erasing));
            if (bus_if.mem_req && !prev_req)
                log_q.push_back({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_din});
            prev_req = bus_if.mem_req;
            if (bus_if.cpu_ack) n_cpu_ack++;
        end
    end

    task automatic chk_log(input string name, input int idx, input logic we,
                           input logic [AW-1:0] addr, input logic [7:0] din);
        logic [AW+8:0] ent;
        if (idx >= log_q.size()) begin
            chk({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            ent = log_q[idx];
            chk({name, "_we"}, 32'(ent[AW+8]), 32'(we));
            chk({name, "_addr"}, 32'(ent[AW+7:8]), 32'(addr));
            chk({name, "_din"}, 32'(ent[7:0]), 32'(din));
        end
    endtask

    task automatic wait_cpu_ack(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus_if.cpu_ack) seen = 1'b1;
        end
        bus_if.cpu_req = 1'b0;
        if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int ls, acks0;
        bus_if.dl_wr = 1'b0; bus_if.dl_addr = '0; bus_if.dl_data = '0;
        bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_din = '0;
        bus_if.erase_start = 1'b0; bus_if.erase_base = '0; bus_if.erase_end = '0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("rst_mem_req", 32'(bus_if.mem_req), 32'(0));
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'(0));
        chk("rst_cpu_ack", 32'(bus_if.cpu_ack), 32'(0));
        chk("rst_ovf", 32'(bus_if.dl_overflow), 32'(0));
        reset = 1'b0;
        tick();

        // Single CPU read
        ack_lat = 3; rd_val = 8'hA5; ls = log_q.size();
        bus_if.cpu_we = 1'b0; bus_if.cpu_addr = AW'('h10); bus_if.cpu_din = 8'h00; bus_if.cpu_req = 1'b1;
        tick();
        chk("rd_latency", 32'(bus_if.mem_req), 32'(1));
        wait_cpu_ack("rd_ack", 20);
        chk("rd_dout", 32'(bus_if.cpu_dout), 32'hA5);
        chk_log("rd_access", ls, 1'b0, AW'('h10), 8'h00);
        repeat (4) tick();

        // Download burst
        ack_lat = 2; ls = log_q.size();
        for (int i = 0; i < 3; i++) begin
            bus_if.dl_wr = 1'b1; bus_if.dl_addr = AW'('h100000 + i);
            bus_if.dl_data = (i == 0) ? 8'hC3 : ((i == 1) ? 8'h12 : 8'h34);
            tick();
        end
        bus_if.dl_wr = 1'b0;
        repeat (15) tick();
        chk_log("dl0", ls,     1'b1, AW'('h100000), 8'hC3);
        chk_log("dl1", ls + 1, 1'b1, AW'('h100001), 8'h12);
        chk_log("dl2", ls + 2, 1'b1, AW'('h100002), 8'h34);
        chk("dl_drained", 32'(bus_if.mem_req), 32'(0));
        chk("dl_no_ovf", 32'(bus_if.dl_overflow), 32'(0));

        // Overflow with mem_ack withheld
        resp_hold = 1'b1; ls = log_q.size();
        for (int i = 0; i < 6; i++) begin
            bus_if.dl_wr = 1'b1; bus_if.dl_addr = AW'('h200 + i); bus_if.dl_data = 8'(8'h50 + i);
            tick();
        end
        bus_if.dl_wr = 1'b0;
        chk("ovf_set", 32'(bus_if.dl_overflow), 32'(1));
        resp_hold = 1'b0;
        repeat (30) tick();
        chk("ovf_nwrites", 32'(log_q.size() - ls), 32'(4));
        chk_log("ovf_first", ls, 1'b1, AW'('h200), 8'h50);
        chk_log("ovf_last", ls + 3, 1'b1, AW'('h203), 8'h53);
        chk("ovf_sticky", 32'(bus_if.dl_overflow), 32'(1));
        pulse_reset();
        chk("ovf_cleared", 32'(bus_if.dl_overflow), 32'(0));
        tick();

        // Contention: three queued downloads against a held CPU write
        ls = log_q.size(); acks0 = n_cpu_ack;
        for (int i = 0; i < 3; i++) begin
            bus_if.dl_wr = 1'b1; bus_if.dl_addr = AW'('h300 + i); bus_if.dl_data = 8'(8'h61 + i);
            if (i == 2) begin
                bus_if.cpu_we = 1'b1; bus_if.cpu_addr = AW'('h40); bus_if.cpu_din = 8'h77;
                bus_if.cpu_req = 1'b1;
            end
            tick();
        end
        bus_if.dl_wr = 1'b0;
        wait_cpu_ack("ct_ack", 40);
        repeat (20) tick();
        chk_log("ct_g0", ls,     1'b1, AW'('h300), 8'h61);
        chk_log("ct_g1", ls + 1, 1'b1, AW'('h40),  8'h77);
        chk_log("ct_g2", ls + 2, 1'b1, AW'('h301), 8'h62);
        chk_log("ct_g3", ls + 3, 1'b1, AW'('h302), 8'h63);
        chk("ct_one_ack", 32'(n_cpu_ack - acks0), 32'(1));

`ifdef DL_MEM_ERASE_EN
        // Zero-fill across the address wrap
        ack_lat = 1; ls = log_q.size();
        bus_if.erase_base = AW'('h1FFFFFE); bus_if.erase_end = AW'('h0000001); bus_if.erase_start = 1'b1;
        tick();
        bus_if.erase_start = 1'b0;
        chk("er_started", 32'(bus_if.erasing), 32'(1));
        repeat (20) tick();
        chk_log("er0", ls,     1'b1, AW'('h1FFFFFE), 8'h00);
        chk_log("er1", ls + 1, 1'b1, AW'('h1FFFFFF), 8'h00);
        chk_log("er2", ls + 2, 1'b1, AW'('h0000000), 8'h00);
        chk("er_nwrites", 32'(log_q.size() - ls), 32'(3));
        chk("er_done", 32'(bus_if.erasing), 32'(0));

        // Empty range
        ls = log_q.size();
        bus_if.erase_base = AW'('h123); bus_if.erase_end = AW'('h123); bus_if.erase_start = 1'b1;
        tick();
        bus_if.erase_start = 1'b0;
        chk("er_empty_flag", 32'(bus_if.erasing), 32'(0));
        repeat (10) tick();
        chk("er_empty_nwrites", 32'(log_q.size() - ls), 32'(0));
`endif

        // Reset in the middle of a CPU read with a queued download
        ack_lat = 2; resp_hold = 1'b1; acks0 = n_cpu_ack;
        bus_if.cpu_we = 1'b0; bus_if.cpu_addr = AW'('h55); bus_if.cpu_req = 1'b1;
        tick();
        chk("mr_req_up", 32'(bus_if.mem_req), 32'(1));
        bus_if.dl_wr = 1'b1; bus_if.dl_addr = AW'('h400); bus_if.dl_data = 8'h99;
        tick();
        bus_if.dl_wr = 1'b0; bus_if.cpu_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_req_drop", 32'(bus_if.mem_req), 32'(0));
        chk("mr_dout_rst", 32'(bus_if.cpu_dout), 32'(0));
        @(negedge clk); inject_ack = 1'b1;
        @(negedge clk); inject_ack = 1'b0;
        resp_hold = 1'b0;
        repeat (10) tick();
        chk("mr_no_ack", 32'(n_cpu_ack - acks0), 32'(0));
        chk("mr_idle", 32'(bus_if.mem_req), 32'(0));
        chk("mr_ovf", 32'(bus_if.dl_overflow), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
